// File: rtl/piece_drop.sv
// piece_drop: owns the settled 4x8 board and the falling piece (spawn, moves, gravity, lock),
// then hands the board to clear_redraw and reloads the cleared result.
module piece_drop #(
    parameter int unsigned SPAWN_X    = 1,
    parameter int unsigned CLEAR_WAIT = 2
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        tick,
    input  logic        move_left,
    input  logic        move_right,
    input  logic [1:0]  piece_in,
    input  logic [31:0] board_ret,
    output logic [31:0] board_out,
    output logic [31:0] disp_out,
    output logic [1:0]  curr_piece,
    output logic [2:0]  state,
    output logic        piece_req,
    output logic        game_over
);
    typedef enum logic [2:0] {FALL = 3'd0, CLEAR = 3'd1, WAIT = 3'd2, SPAWN = 3'd3, OVER = 3'd4} state_t;
    localparam logic [3:0] SX    = 4'(SPAWN_X);
    localparam logic [7:0] WLAST = 8'(CLEAR_WAIT - 1);

    // Coordinates are 4 bits wide so that x-1 at column 0 wraps to 15 and reads as out of bounds.
    function automatic logic [31:0] cells(input logic [1:0] t, input logic [3:0] px, input logic [3:0] py);
        logic [31:0] row;
        row = {28'd0, t[0] ? 4'b0011 : 4'b0001} << px;
        return (row << {py, 2'b00}) | (t[1] ? row << {py + 4'd1, 2'b00} : 32'd0);
    endfunction

    function automatic logic bad(input logic [1:0] t, input logic [3:0] px, input logic [3:0] py,
                                 input logic [31:0] b);
        logic oob;
        oob = ({1'b0, px} + (t[0] ? 5'd2 : 5'd1) > 5'd4) || ({1'b0, py} + (t[1] ? 5'd2 : 5'd1) > 5'd8);
        return oob || |(cells(t, px, py) & b);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] board_q, board_d;
    logic [1:0]  piece_q, piece_d;
    logic [1:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        over_q, over_d;
    logic [3:0]  xe, ye;
    logic [31:0] cur_mask;

    assign xe       = {2'b00, x_q};
    assign ye       = {1'b0, y_q};
    assign cur_mask = cells(piece_q, xe, ye);

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        piece_d = piece_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        over_d  = over_q;
        case (state_q)
            SPAWN: begin
                piece_d = piece_in;
                x_d     = SX[1:0];
                y_d     = piece_in[1] ? 3'd6 : 3'd7;
                if (bad(piece_in, SX, piece_in[1] ? 4'd6 : 4'd7, board_q)) begin
                    state_d = OVER;
                    over_d  = 1'b1;
                end else begin
                    state_d = FALL;
                    req_d   = 1'b1;
                end
            end
            FALL: begin
                if (tick) begin
                    if (y_q != 3'd0 && !bad(piece_q, xe, ye - 4'd1, board_q)) begin
                        y_d = y_q - 3'd1;
                    end else begin
                        board_d = board_q | cur_mask;
                        state_d = CLEAR;
                    end
                end else if (move_left && !move_right && !bad(piece_q, xe - 4'd1, ye, board_q)) begin
                    x_d = x_q - 2'd1;
                end else if (move_right && !move_left && !bad(piece_q, xe + 4'd1, ye, board_q)) begin
                    x_d = x_q + 2'd1;
                end
            end
            CLEAR: begin
                state_d = WAIT;
                cnt_d   = 8'd0;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == WLAST) begin
                    board_d = board_ret;
                    state_d = SPAWN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q <= SPAWN;
            board_q <= 32'd0;
            piece_q <= 2'd0;
            x_q     <= SX[1:0];
            y_q     <= 3'd0;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            piece_q <= piece_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            over_q  <= over_d;
        end
    end

    assign board_out  = board_q;
    assign disp_out   = (state_q == FALL) ? (board_q | cur_mask) : board_q;
    assign curr_piece = piece_q;
    assign state      = state_q;
    assign piece_req  = req_q;
    assign game_over  = over_q;
endmodule

// File: tb/tb_piece_drop.sv
// tb_piece_drop: random and directed stimulus against a cell-grid game model; expectations are
// queued per cycle and a monitor pops and compares them after each clock edge.
module tb_piece_drop;
    localparam int SX = 1;
    localparam int CW = 2;
    localparam int M_FALL = 0, M_CLEAR = 1, M_WAIT = 2, M_SPAWN = 3, M_OVER = 4;

    logic        clka = 1'b0;
    logic        restart = 1'b0, tick = 1'b0, move_left = 1'b0, move_right = 1'b0;
    logic [1:0]  piece_in = 2'd0;
    logic [31:0] board_ret = 32'd0;
    logic [31:0] board_out, disp_out;
    logic [1:0]  curr_piece;
    logic [2:0]  state;
    logic        piece_req, game_over;

    piece_drop #(.SPAWN_X(SX), .CLEAR_WAIT(CW)) dut (
        .clka(clka), .restart(restart), .tick(tick), .move_left(move_left), .move_right(move_right),
        .piece_in(piece_in), .board_ret(board_ret), .board_out(board_out), .disp_out(disp_out),
        .curr_piece(curr_piece), .state(state), .piece_req(piece_req), .game_over(game_over)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [31:0] board;
        logic [31:0] disp;
        logic [2:0]  st;
        logic [1:0]  pc;
        logic        req;
        logic        ov;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Game model: a grid of cells and a piece described by type and anchor.
    bit cells[8][4];
    int mode, ptype, px, py, wcnt;
    bit m_req, m_over;

    function automatic int wd(input int t); return (t % 2 == 1) ? 2 : 1; endfunction
    function automatic int ht(input int t); return (t >= 2) ? 2 : 1; endfunction

    function automatic bit blocked(input int t, input int x, input int y);
        for (int dy = 0; dy < ht(t); dy++)
            for (int dx = 0; dx < wd(t); dx++) begin
                int cx, cy;
                cx = x + dx;
                cy = y + dy;
                if (cx < 0 || cx > 3 || cy < 0 || cy > 7) return 1'b1;
                if (cells[cy][cx]) return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic logic [31:0] shape(input int t, input int x, input int y);
        logic [31:0] m;
        m = 32'd0;
        for (int dy = 0; dy < ht(t); dy++)
            for (int dx = 0; dx < wd(t); dx++) m[4 * (y + dy) + x + dx] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] packb();
        logic [31:0] b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++) b[4 * r + c] = cells[r][c];
        return b;
    endfunction

    task automatic m_step(input bit r, input bit tk, input bit ml, input bit mr, input int pin,
                          input logic [31:0] br);
        m_req = 1'b0;
        if (r) begin
            for (int i = 0; i < 8; i++) for (int c = 0; c < 4; c++) cells[i][c] = 1'b0;
            ptype = 0; px = SX; py = 0; wcnt = 0; m_over = 1'b0; mode = M_SPAWN;
        end else if (mode == M_SPAWN) begin
            ptype = pin; px = SX; py = 8 - ht(pin);
            if (blocked(ptype, px, py)) begin
                mode = M_OVER;
                m_over = 1'b1;
            end else begin
                mode = M_FALL;
                m_req = 1'b1;
            end
        end else if (mode == M_FALL) begin
            if (tk) begin
                if (py > 0 && !blocked(ptype, px, py - 1)) py--;
                else begin
                    for (int dy = 0; dy < ht(ptype); dy++)
                        for (int dx = 0; dx < wd(ptype); dx++) cells[py + dy][px + dx] = 1'b1;
                    mode = M_CLEAR;
                end
            end else if (ml != mr) begin
                int nx;
                nx = mr ? px + 1 : px - 1;
                if (!blocked(ptype, nx, py)) px = nx;
            end
        end else if (mode == M_CLEAR) begin
            mode = M_WAIT;
            wcnt = 0;
        end else if (mode == M_WAIT) begin
            if (wcnt == CW - 1) begin
                for (int i = 0; i < 8; i++) for (int c = 0; c < 4; c++) cells[i][c] = br[4 * i + c];
                mode = M_SPAWN;
            end
            wcnt++;
        end
    endtask

    function automatic exp_t m_out();
        exp_t e;
        e.board = packb();
        e.disp  = (mode == M_FALL) ? (e.board | shape(ptype, px, py)) : e.board;
        e.st    = 3'(mode);
        e.pc    = 2'(ptype);
        e.req   = m_req;
        e.ov    = m_over;
        return e;
    endfunction

    always @(posedge clka) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("board_out", board_out, e.board);
            cmp("disp_out", disp_out, e.disp);
            cmp("state", 32'(state), 32'(e.st));
            cmp("curr_piece", 32'(curr_piece), 32'(e.pc));
            cmp("piece_req", 32'(piece_req), 32'(e.req));
            cmp("game_over", 32'(game_over), 32'(e.ov));
        end
    end

    task automatic cyc(input bit r, input bit tk, input bit ml, input bit mr, input int pin,
                       input logic [31:0] br);
        @(negedge clka);
        restart = r; tick = tk; move_left = ml; move_right = mr;
        piece_in = 2'(pin); board_ret = br;
        m_step(r, tk, ml, mr, pin, br);
        sb.push_back(m_out());
        @(posedge clka);
        #2;
    endtask

    task automatic idle(input int n, input logic [31:0] br);
        repeat (n) cyc(0, 0, 0, 0, 0, br);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cmp("rst_state", 32'(state), 3);
        cmp("rst_board", board_out, 0);
        // Square drops from row 6 to the floor and locks.
        cyc(0, 0, 0, 0, 3, 0);
        cmp("t1_req", 32'(piece_req), 1);
        cmp("t1_spawn_disp", disp_out, 32'h66000000);
        repeat (6) cyc(0, 1, 0, 0, 0, 0);
        cmp("t1_floor_disp", disp_out, 32'h00000066);
        cyc(0, 1, 0, 0, 0, 0);
        cmp("t1_lock_board", board_out, 32'h00000066);
        cmp("t1_clear_state", 32'(state), 1);
        idle(1, 0);
        cmp("t1_wait_state", 32'(state), 2);
        idle(2, 0);
        cmp("t1_respawn_state", 32'(state), 3);
        // Hbars pushed against both walls.
        cyc(0, 0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 1, 0, 0, 0);
        cmp("t2_left_wall", disp_out, 32'h30000000);
        repeat (8) cyc(0, 1, 0, 0, 0, 0);
        cmp("t2_lock1", board_out, 32'h00000003);
        idle(3, 32'h00000003);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        cmp("t2_right_wall", disp_out, 32'hC0000003);
        repeat (8) cyc(0, 1, 0, 0, 0, 0);
        cmp("t2_lock2", board_out, 32'h0000000F);
        idle(3, 0);
        cmp("t2_cleared", board_out, 0);
        cmp("t2_spawn_state", 32'(state), 3);
        // Dot blocked by a settled cell; tick beats a simultaneous move.
        cyc(0, 0, 0, 0, 0, 0);
        repeat (8) cyc(0, 1, 0, 0, 0, 0);
        idle(3, 32'h00000002);
        cmp("t3_ret_board", board_out, 32'h00000002);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cmp("t4_tick_wins", disp_out, 32'h02000002);
        cyc(0, 0, 1, 0, 0, 0);
        repeat (6) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cmp("t3_blocked", disp_out, 32'h00000003);
        cyc(0, 1, 0, 0, 0, 0);
        cmp("t3_lock", board_out, 32'h00000003);
        // Spawn onto an occupied cell ends the game until restart.
        idle(3, 32'h20000000);
        cyc(0, 0, 0, 0, 0, 0);
        cmp("t5_over_state", 32'(state), 4);
        cmp("t5_over_flag", 32'(game_over), 1);
        repeat (10) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), $urandom);
        cmp("t5_hold_state", 32'(state), 4);
        cmp("t5_hold_board", board_out, 32'h20000000);
        cyc(1, 0, 0, 0, 0, 0);
        cmp("t5_restart_over", 32'(game_over), 0);
        cmp("t5_restart_board", board_out, 0);
        // Restart in the middle of FALL and of WAIT.
        cyc(0, 0, 0, 0, 2, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 3, 32'hFFFFFFFF);
        cmp("t6_fall_state", 32'(state), 3);
        cmp("t6_fall_disp", disp_out, 0);
        cyc(0, 0, 0, 0, 3, 0);
        repeat (7) cyc(0, 1, 0, 0, 0, 0);
        idle(2, 32'hFFFFFFFF);
        cyc(1, 0, 0, 0, 0, 32'hFFFFFFFF);
        cmp("t6_wait_state", 32'(state), 3);
        cmp("t6_wait_board", board_out, 0);
        cmp("t6_wait_piece", 32'(curr_piece), 0);
        repeat (3000) begin
            logic [31:0] br;
            br = $urandom & $urandom & $urandom;
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), br);
        end
        idle(1, 0);
        cmp("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
